softex_tcdm_responder: RTL and testbench

// - Multi-port TCDM responder (slave end) for the MP x 64-bit narrow master ports the SoftEx wrapper drives.
// - Serves N_PORTS request streams from a word-interleaved banked scratchpad.
// - Resolves bank conflicts with per-bank round-robin arbitration; returns read data one cycle after grant.
// - Buffers responses per port under r_ready backpressure.
// - Used as the memory end in block-level testbenches, and as a standalone local buffer.

---
 rtl/softex_tcdm_responder_pkg.sv | 33 +++
 rtl/softex_tcdm_responder_if.sv | 33 +++
 rtl/softex_tcdm_rr_arbiter.sv | 40 ++++
 rtl/softex_tcdm_responder.sv | 168 ++++++++++++++++
 tb/tb_softex_tcdm_responder.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softex_tcdm_responder_pkg.sv
// Shared types and constants for the SoftEx narrow TCDM responder.
package softex_tcdm_responder_pkg;

    localparam int unsigned TCDM_NARROW_DW       = 64;
    localparam int unsigned TCDM_NARROW_BW       = TCDM_NARROW_DW / 8;
    localparam int unsigned TCDM_RESP_FIFO_DEPTH = 2;
    localparam int unsigned TCDM_ID_W            = 8;

    typedef struct packed {
        logic [31:0]                 add;
        logic                        wen;
        logic [TCDM_NARROW_BW-1:0]   be;
        logic [TCDM_NARROW_DW-1:0]   data;
        logic [TCDM_ID_W-1:0]        id;
    } tcdm_nreq_t;

    typedef struct packed {
        logic [TCDM_NARROW_DW-1:0]   data;
        logic [TCDM_ID_W-1:0]        id;
        logic                        opc;
    } tcdm_nresp_t;

    // Expand per-byte enables into a full-width bit mask.
    function automatic logic [TCDM_NARROW_DW-1:0] beToMask(input logic [TCDM_NARROW_BW-1:0] be);
        logic [TCDM_NARROW_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < int'(TCDM_NARROW_BW); i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/softex_tcdm_responder_if.sv
// Narrow multi-port TCDM bus bundle; the master drives requests and r_ready,
// the slave (responder) drives grants and responses.
interface softex_tcdm_responder_if
    import softex_tcdm_responder_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ID_W    = 8
) ();

    logic [N_PORTS-1:0]                          req;
    logic [N_PORTS-1:0]                          gnt;
    logic [N_PORTS-1:0][31:0]                    add;
    logic [N_PORTS-1:0]                          wen;
    logic [N_PORTS-1:0][TCDM_NARROW_BW-1:0]      be;
    logic [N_PORTS-1:0][TCDM_NARROW_DW-1:0]      data;
    logic [N_PORTS-1:0][ID_W-1:0]                id;
    logic [N_PORTS-1:0]                          r_ready;
    logic [N_PORTS-1:0]                          r_valid;
    logic [N_PORTS-1:0][TCDM_NARROW_DW-1:0]      r_data;
    logic [N_PORTS-1:0][ID_W-1:0]                r_id;
    logic [N_PORTS-1:0]                          r_opc;

    modport master (
        output req, add, wen, be, data, id, r_ready,
        input  gnt, r_valid, r_data, r_id, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, id, r_ready,
        output gnt, r_valid, r_data, r_id, r_opc
    );

endinterface

// File: rtl/softex_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: picks the first requester at or after
// the pointer and moves the pointer just past the winner on every grant.
module softex_tcdm_rr_arbiter #(
    parameter int unsigned N_PORTS = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_PORTS-1:0] req_i,
    output logic [N_PORTS-1:0] gnt_o
);

    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // Scan requesters starting from the priority pointer; first hit wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % int'(N_PORTS)]) begin
                found = 1'b1;
                gnt_o[(int'(ptr_q) + i) % int'(N_PORTS)] = 1'b1;
                ptr_d = PTR_W'((int'(ptr_q) + i + 1) % int'(N_PORTS));
            end
        end
    end

    // Priority pointer register, cleared to port 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/softex_tcdm_responder.sv
// Multi-port TCDM responder: word-interleaved banked scratchpad with per-bank
// round-robin arbitration and a 2-deep response FIFO per port.
// Optional feature macro: SOFTEX_TCDM_RESP_ERR_EN (out-of-range detection;
// when undefined the address wraps modulo the memory size and r_opc stays 0).
module softex_tcdm_responder
    import softex_tcdm_responder_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned N_BANKS    = 8,
    parameter int unsigned BANK_DEPTH = 256,
    parameter int unsigned ID_W       = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    softex_tcdm_responder_if.slave tcdm
);

    localparam int unsigned BANK_W     = $clog2(N_BANKS);
    localparam int unsigned ROW_W      = $clog2(BANK_DEPTH);
    localparam int unsigned FIFO_PTR_W = $clog2(TCDM_RESP_FIFO_DEPTH);
    localparam int unsigned CNT_W      = FIFO_PTR_W + 1;
`ifdef SOFTEX_TCDM_RESP_ERR_EN
    localparam logic [31:0] MEM_BYTES  = 32'(N_BANKS * BANK_DEPTH * TCDM_NARROW_BW);
`endif

    typedef struct packed {
        logic [TCDM_NARROW_DW-1:0] data;
        logic [ID_W-1:0]           id;
        logic                      opc;
    } respEntry_t;

    logic [N_PORTS-1:0][BANK_W-1:0]     bankSel;
    logic [N_PORTS-1:0][ROW_W-1:0]      rowSel;
    logic [N_PORTS-1:0]                 outOfRange;
    logic [N_PORTS-1:0]                 slotFree;
    logic [N_PORTS-1:0]                 eligible;
    logic [N_BANKS-1:0][N_PORTS-1:0]    bankReq;
    logic [N_BANKS-1:0][N_PORTS-1:0]    bankGnt;
    logic [N_PORTS-1:0]                 portGnt;
    logic [N_PORTS-1:0]                 pushEn;
    logic [N_PORTS-1:0]                 popEn;
    logic [N_PORTS-1:0]                 fifoValid;
    respEntry_t [N_PORTS-1:0]           readEntry;

    logic [TCDM_NARROW_DW-1:0]          mem [N_BANKS][BANK_DEPTH];

    respEntry_t                         fifoMem_q [N_PORTS][TCDM_RESP_FIFO_DEPTH];
    logic [N_PORTS-1:0][FIFO_PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [N_PORTS-1:0][FIFO_PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [N_PORTS-1:0][CNT_W-1:0]      fifoCount_q, fifoCount_d;

    // Address decode and eligibility. Reads are pushed straight into the FIFO
    // at the grant edge, so nothing is ever in flight between grant and push
    // and the slot check reduces to the FIFO occupancy. Writes need no slot.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            bankSel[p] = BANK_W'((tcdm.add[p] - BASE_ADDR) >> 3);
            rowSel[p]  = ROW_W'((tcdm.add[p] - BASE_ADDR) >> (3 + BANK_W));
`ifdef SOFTEX_TCDM_RESP_ERR_EN
            outOfRange[p] = ((tcdm.add[p] - BASE_ADDR) >= MEM_BYTES);
`else
            outOfRange[p] = 1'b0;
`endif
            slotFree[p] = (fifoCount_q[p] < CNT_W'(TCDM_RESP_FIFO_DEPTH));
            eligible[p] = rst_ni & tcdm.req[p] & (~tcdm.wen[p] | slotFree[p]);
        end
    end

    // Route each eligible request to the arbiter of the bank it targets.
    always_comb begin
        bankReq = '0;
        for (int b = 0; b < int'(N_BANKS); b++) begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (eligible[p] && (bankSel[p] == BANK_W'(b))) begin
                    bankReq[b][p] = 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < int'(N_BANKS); b++) begin : gen_bank_arb
        softex_tcdm_rr_arbiter #(
            .N_PORTS (N_PORTS)
        ) i_arb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (bankReq[b]),
            .gnt_o   (bankGnt[b])
        );
    end

    // A port targets exactly one bank, so OR-ing bank grants gives its grant.
    always_comb begin
        portGnt = '0;
        for (int b = 0; b < int'(N_BANKS); b++) begin
            portGnt = portGnt | bankGnt[b];
        end
    end

    assign tcdm.gnt = portGnt;
    assign pushEn   = portGnt & tcdm.wen;
    assign popEn    = fifoValid & tcdm.r_ready;

    // Response entry captured at the grant edge; out-of-range reads return zero data.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            readEntry[p].id   = tcdm.id[p];
            readEntry[p].opc  = outOfRange[p];
            readEntry[p].data = outOfRange[p] ? '0 : mem[bankSel[p]][rowSel[p]];
        end
    end

    // Byte-enabled bank writes; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            if (portGnt[p] && !tcdm.wen[p] && !outOfRange[p]) begin
                mem[bankSel[p]][rowSel[p]] <=
                    (mem[bankSel[p]][rowSel[p]] & ~beToMask(tcdm.be[p])) |
                    (tcdm.data[p] & beToMask(tcdm.be[p]));
            end
        end
    end

    // FIFO pointer and occupancy next-state; push and pop together keep the count.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            wrPtr_d[p]     = wrPtr_q[p] + FIFO_PTR_W'(pushEn[p]);
            rdPtr_d[p]     = rdPtr_q[p] + FIFO_PTR_W'(popEn[p]);
            fifoCount_d[p] = fifoCount_q[p] + CNT_W'(pushEn[p]) - CNT_W'(popEn[p]);
        end
    end

    // Response FIFO state and storage; reset discards all queued responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            for (int p = 0; p < int'(N_PORTS); p++) begin
                for (int e = 0; e < int'(TCDM_RESP_FIFO_DEPTH); e++) begin
                    fifoMem_q[p][e] <= '0;
                end
            end
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (pushEn[p]) begin
                    fifoMem_q[p][wrPtr_q[p]] <= readEntry[p];
                end
            end
        end
    end

    // FIFO head drives the response channel; valid depends only on registered state.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            fifoValid[p]      = (fifoCount_q[p] != '0);
            tcdm.r_valid[p]   = fifoValid[p];
            tcdm.r_data[p]    = fifoMem_q[p][rdPtr_q[p]].data;
            tcdm.r_id[p]      = fifoMem_q[p][rdPtr_q[p]].id;
            tcdm.r_opc[p]     = fifoMem_q[p][rdPtr_q[p]].opc;
        end
    end

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Self-checking bench for softex_tcdm_responder: a reference memory model plus
// per-port response scoreboards, and directed grant/latency/reset scenarios.
module tb_softex_tcdm_responder;
    import softex_tcdm_responder_pkg::*;

    localparam int          NP        = 4;
    localparam logic [31:0] BASE      = 32'h0;
    localparam int          MEM_WORDS = 8 * 256;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 8);
`ifdef SOFTEX_TCDM_RESP_ERR_EN
    localparam bit          ERR_EN    = 1'b1;
`else
    localparam bit          ERR_EN    = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    tcdm_nresp_t  sbQ [NP][$];
    logic [63:0]  modelMem [int];

    softex_tcdm_responder_if #(.N_PORTS(NP), .ID_W(8)) tcdm ();

    softex_tcdm_responder #(
        .N_PORTS    (NP),
        .N_BANKS    (8),
        .BANK_DEPTH (256),
        .ID_W       (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tcdm   (tcdm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] add, input logic wen,
                                 input logic [7:0] be, input logic [63:0] data, input logic [7:0] id);
        tcdm.req[port]  = 1'b1;
        tcdm.add[port]  = add;
        tcdm.wen[port]  = wen;
        tcdm.be[port]   = be;
        tcdm.data[port] = data;
        tcdm.id[port]   = id;
    endtask

    // Issue one request, hold it until granted (bounded), then drop it.
    task automatic doAccess(input int port, input logic [31:0] add, input logic wen,
                            input logic [7:0] be, input logic [63:0] data, input logic [7:0] id);
        bit granted;
        granted = 1'b0;
        @(posedge clk); #1;
        applyStimulus(port, add, wen, be, data, id);
        for (int c = 0; c < 20 && !granted; c++) begin
            @(negedge clk);
            if (tcdm.gnt[port]) granted = 1'b1;
        end
        checkOutput($sformatf("gnt_arrived_p%0d", port), 64'(granted), 64'd1);
        @(posedge clk); #1;
        tcdm.req[port] = 1'b0;
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) sbQ[p].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int wordKey(input logic [31:0] a);
        return int'(((a - BASE) >> 3) % 32'(MEM_WORDS));
    endfunction

    function automatic bit isOor(input logic [31:0] a);
        return ERR_EN && ((a - BASE) >= MEM_BYTES);
    endfunction

    function automatic logic [63:0] maskOf(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Scoreboard monitor: checks valid against outstanding reads, compares
    // popped responses, and records new grants into the model.
    always @(negedge clk) begin
        tcdm_nresp_t e;
        logic [63:0] old;
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                checkOutput($sformatf("rvalid_p%0d", p), 64'(tcdm.r_valid[p]), 64'(sbQ[p].size() != 0));
                if (tcdm.r_valid[p] && tcdm.r_ready[p] && sbQ[p].size() != 0) begin
                    e = sbQ[p].pop_front();
                    checkOutput($sformatf("rdata_p%0d", p), tcdm.r_data[p], e.data);
                    checkOutput($sformatf("rid_p%0d", p), 64'(tcdm.r_id[p]), 64'(e.id));
                    checkOutput($sformatf("ropc_p%0d", p), 64'(tcdm.r_opc[p]), 64'(e.opc));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (tcdm.req[p] && tcdm.gnt[p]) begin
                    if (tcdm.wen[p]) begin
                        e.id = tcdm.id[p];
                        if (isOor(tcdm.add[p])) begin
                            e.data = '0;
                            e.opc  = 1'b1;
                        end else begin
                            e.data = modelMem.exists(wordKey(tcdm.add[p])) ? modelMem[wordKey(tcdm.add[p])] : 64'h0;
                            e.opc  = 1'b0;
                        end
                        sbQ[p].push_back(e);
                    end else if (!isOor(tcdm.add[p])) begin
                        old = modelMem.exists(wordKey(tcdm.add[p])) ? modelMem[wordKey(tcdm.add[p])] : 64'h0;
                        modelMem[wordKey(tcdm.add[p])] = (old & ~maskOf(tcdm.be[p])) | (tcdm.data[p] & maskOf(tcdm.be[p]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          granted;
        logic [3:0]  g;

        rst_n        = 1'b0;
        tcdm.req     = '0;
        tcdm.add     = '0;
        tcdm.wen     = '1;
        tcdm.be      = '0;
        tcdm.data    = '0;
        tcdm.id      = '0;
        tcdm.r_ready = '1;

        // Reset state, with a request pending to show grants are held off.
        applyStimulus(0, 32'h0, 1'b1, 8'h00, 64'h0, 8'h1);
        repeat (2) @(negedge clk);
        checkOutput("reset_gnt", 64'(tcdm.gnt), 64'h0);
        checkOutput("reset_rvalid", 64'(tcdm.r_valid), 64'h0);
        checkOutput("reset_rdata0", tcdm.r_data[0], 64'h0);
        checkOutput("reset_rid0", 64'(tcdm.r_id[0]), 64'h0);
        checkOutput("reset_ropc", 64'(tcdm.r_opc), 64'h0);
        tcdm.req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: write then read back, one-cycle latency, id echo.
        doAccess(0, 32'h0, 1'b0, 8'hFF, 64'hDEAD_BEEF_0123_4567, 8'h0);
        doAccess(0, 32'h0, 1'b1, 8'h00, 64'h0, 8'd5);
        @(negedge clk);
        checkOutput("t1_rvalid", 64'(tcdm.r_valid[0]), 64'd1);
        checkOutput("t1_rdata", tcdm.r_data[0], 64'hDEAD_BEEF_0123_4567);
        checkOutput("t1_rid", 64'(tcdm.r_id[0]), 64'd5);

        // Preload words 0x08..0x48 so every later read has known content.
        for (int i = 1; i < 10; i++) begin
            doAccess(i % NP, 32'(i * 8), 1'b0, 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(i), 8'h0);
        end

        // T2: same-bank contention from a fresh reset; grant order 0,1,2,3.
        resetDut();
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) applyStimulus(p, 32'h40, 1'b1, 8'h00, 64'h0, 8'(10 + p));
        for (int k = 0; k < NP; k++) begin
            @(negedge clk);
            g = tcdm.gnt;
            checkOutput($sformatf("t2_gnt_round1_%0d", k), 64'(g), 64'(4'b0001 << k));
            @(posedge clk); #1;
            tcdm.req = tcdm.req & ~g;
        end
        tcdm.req = '0;
        @(posedge clk); #1;
        applyStimulus(0, 32'h40, 1'b1, 8'h00, 64'h0, 8'd14);
        applyStimulus(3, 32'h40, 1'b1, 8'h00, 64'h0, 8'd15);
        @(negedge clk);
        checkOutput("t2_gnt_round2_first", 64'(tcdm.gnt), 64'h1);
        @(posedge clk); #1;
        tcdm.req[0] = 1'b0;
        @(negedge clk);
        checkOutput("t2_gnt_round2_second", 64'(tcdm.gnt), 64'h8);
        @(posedge clk); #1;
        tcdm.req[3] = 1'b0;

        // T3: distinct banks all granted together, all responses next cycle.
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) applyStimulus(p, 32'(p * 8), 1'b1, 8'h00, 64'h0, 8'(40 + p));
        @(negedge clk);
        checkOutput("t3_gnt_all", 64'(tcdm.gnt), 64'hF);
        @(posedge clk); #1;
        tcdm.req = '0;
        @(negedge clk);
        checkOutput("t3_rvalid_all", 64'(tcdm.r_valid), 64'hF);

        // T4: backpressure on port 1 stalls grants after two reads.
        repeat (2) @(posedge clk);
        #1;
        tcdm.r_ready[1] = 1'b0;
        applyStimulus(1, 32'h08, 1'b1, 8'h00, 64'h0, 8'd20);
        @(negedge clk);
        checkOutput("t4_gnt0", 64'(tcdm.gnt[1]), 64'd1);
        @(posedge clk); #1;
        tcdm.id[1] = 8'd21;
        @(negedge clk);
        checkOutput("t4_gnt1", 64'(tcdm.gnt[1]), 64'd1);
        @(posedge clk); #1;
        tcdm.id[1] = 8'd22;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_stall%0d", c), 64'(tcdm.gnt[1]), 64'd0);
        end
        @(posedge clk); #1;
        tcdm.r_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("t4_stall_ready_cycle", 64'(tcdm.gnt[1]), 64'd0);
        granted = 1'b0;
        for (int c = 0; c < 5 && !granted; c++) begin
            if (c != 0) @(negedge clk);
            else begin
                @(posedge clk);
                @(negedge clk);
            end
            if (tcdm.gnt[1]) granted = 1'b1;
        end
        checkOutput("t4_regrant", 64'(granted), 64'd1);
        @(posedge clk); #1;
        tcdm.req[1] = 1'b0;

        // T5: partial write merges into existing word.
        doAccess(2, 32'h20, 1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0);
        doAccess(2, 32'h20, 1'b0, 8'h0F, 64'h1111_1111_2222_2222, 8'h0);
        doAccess(2, 32'h20, 1'b1, 8'h00, 64'h0, 8'd7);
        @(negedge clk);
        checkOutput("t5_rdata", tcdm.r_data[2], 64'hFFFF_FFFF_2222_2222);

        // T6: reset with two queued responses discards them.
        @(posedge clk); #1;
        tcdm.r_ready[2] = 1'b0;
        doAccess(2, 32'h10, 1'b1, 8'h00, 64'h0, 8'd30);
        doAccess(2, 32'h10, 1'b1, 8'h00, 64'h0, 8'd31);
        @(negedge clk);
        checkOutput("t6_queued", 64'(tcdm.r_valid[2]), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) sbQ[p].delete();
        #1;
        checkOutput("t6_rvalid_in_reset", 64'(tcdm.r_valid), 64'h0);
        tcdm.r_ready[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_rvalid_after%0d", c), 64'(tcdm.r_valid), 64'h0);
        end

        // Address at the end of memory: out-of-range with the error option,
        // aliasing word 0 without it; the model covers both.
        doAccess(0, 32'h4000, 1'b0, 8'hFF, 64'h0BAD_0BAD_CAFE_F00D, 8'h0);
        doAccess(1, 32'h4000, 1'b1, 8'h00, 64'h0, 8'd9);
        @(negedge clk);
`ifdef SOFTEX_TCDM_RESP_ERR_EN
        checkOutput("err_ropc", 64'(tcdm.r_opc[1]), 64'd1);
        checkOutput("err_rdata", tcdm.r_data[1], 64'h0);
`else
        checkOutput("wrap_rdata", tcdm.r_data[1], 64'h0BAD_0BAD_CAFE_F00D);
`endif
        doAccess(0, 32'h0, 1'b1, 8'h00, 64'h0, 8'd4);

        // Drain and confirm nothing outstanding.
        repeat (5) @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("drain_p%0d", p), 64'(sbQ[p].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
